// File: rtl/sha3_pad_block_ctrl.sv
// SHA-3 rate-block packer: gathers 64-bit message words into a 576-bit block,
// applies 0x06 ... 0x80 domain padding and hands the block on through valid/ready.
module sha3_pad_block_ctrl #(
    parameter int RATE_WORDS = 9,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [63:0]                in,
    input  logic                       in_valid,
    input  logic                       is_last,
    input  logic [2:0]                 byte_num,
    output logic                       in_ready,
    output logic [64*RATE_WORDS-1:0]   out,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        FULL = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_WORDS - 1);

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [RATE_WORDS-1:0][63:0] buf_q, buf_d;
    logic                        last_q, last_d;
    logic                        wr_en, clr, accept;
    logic [63:0]                 wr_word, keep_mask, pad_word;

    assign accept    = in_valid && (state_q == FILL);
    // Valid bytes sit at the MSB end; everything below them is dropped.
    assign keep_mask = ~({64{1'b1}} >> {byte_num, 3'b000});
    assign pad_word  = (in & keep_mask) | (64'h0600000000000000 >> {byte_num, 3'b000});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wr_en   = 1'b0;
        clr     = 1'b0;
        wr_word = '0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (!is_last) begin
                        wr_word = in;
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            state_d = FULL;
                            last_d  = 1'b0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (cnt_q == LAST_IDX) begin
                        wr_word = pad_word | 64'h80;
                        cnt_d   = '0;
                        state_d = FULL;
                        last_d  = 1'b1;
                    end else begin
                        wr_word = pad_word;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                wr_en = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    wr_word = 64'h80;
                    cnt_d   = '0;
                    state_d = FULL;
                    last_d  = 1'b1;
                end else begin
                    wr_word = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            FULL: begin
                if (out_ready) begin
                    clr     = 1'b1;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Word 0 lives in the most significant slot of the packed buffer.
    always_comb begin
        buf_d = clr ? '0 : buf_q;
        if (wr_en) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
                if (cnt_q == CNT_W'(i)) buf_d[RATE_WORDS-1-i] = wr_word;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == FULL);
        out       = buf_q;
        out_last  = last_q;
    end

endmodule

// File: doc/sha3_pad_block_ctrl.md
Name: sha3_pad_block_ctrl

Overview:
- Sequencing controller for the 64-bit word padder in the high-throughput SHA-3 core.
- Accepts the message as a stream of 64-bit big-endian words and applies SHA-3 domain padding to the final word: 0x06 after the message, then 0x80 in the last byte of the block.
- Packs words into a full 576-bit rate block and hands the block to the permutation core through a valid/ready handshake.
- Zero-fills the rest of the block after the last word and marks the final block.

Parameters:
- RATE_WORDS, 9, number of 64-bit words per rate block (576 bits).
- CNT_W, 4, width of the word counter; must satisfy 2^CNT_W > RATE_WORDS.

Ports:
- clk  input  1  core clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  64  message word; first message byte is in[63:56].
- in_valid  input  1  in/byte_num/is_last are valid this cycle.
- is_last  input  1  this word is the final word of the message.
- byte_num  input  3  valid message bytes in the last word (0..7); ignored unless is_last.
- in_ready  output  1  controller accepts a word this cycle.
- out  output  64*RATE_WORDS  padded block; word 0 is at the MSBs.
- out_valid  output  1  out holds a complete block.
- out_last  output  1  the presented block is the final block of the message.
- out_ready  input  1  downstream consumes the block.

Behaviour:
- Reset (reset_n low, asynchronous) forces the following values:
  - state=FILL, cnt=0, buffer=0.
  - out=0, out_valid=0, out_last=0.
  - in_ready follows state and is 1 in FILL once reset_n is high.
  - Reset mid-block discards all partial data; no block is emitted.
- States: FILL, PAD, FULL.
  - in_ready = (state==FILL).
  - out_valid = (state==FULL).
- An input word is accepted only when in_valid && in_ready.
- FILL, accepted word with is_last=0:
  - buffer[cnt] <= in.
  - If cnt==RATE_WORDS-1: cnt<=0, state<=FULL, out_last<=0.
  - Otherwise cnt<=cnt+1.
- FILL, accepted word with is_last=1:
  - Padded word w = top 8*byte_num bits of in, then byte 0x06, then zeros.
  - byte_num=0 gives w=64'h0600000000000000.
  - If cnt==RATE_WORDS-1: buffer[cnt] <= w | 64'h80, state<=FULL, out_last<=1.
  - Otherwise buffer[cnt] <= w, cnt<=cnt+1, state<=PAD.
- PAD: writes one word per cycle, with no input accepted.
  - If cnt<RATE_WORDS-1: buffer[cnt] <= 0, cnt++.
  - If cnt==RATE_WORDS-1: buffer[cnt] <= 64'h80, cnt<=0, state<=FULL, out_last<=1.
- FULL: out presents the buffer; out and out_last are held stable while out_valid && !out_ready.
  - On out_ready: buffer<=0, out_last<=0, state<=FILL.
  - in_ready rises the cycle after the handshake; there is no same-cycle pass-through.
- Latency:
  - out_valid rises 1 cycle after the accepting edge of the block's 9th word.
  - For a last word at index k<8, out_valid rises (8-k)+1 cycles after acceptance.
- Message length a multiple of 8 bytes: the source sends an extra is_last word with byte_num=0. If that word is at index 0, it produces a full padding-only block.
- Message filling exactly a block: the next block starts with is_last/byte_num=0 and is emitted as its own final block.
- Bits of in below the valid bytes are never propagated into the padded word.
- Byte 0x06 and 0x80 land in the same byte only when byte_num=7 at index RATE_WORDS-1, giving 0x86.

Test Plan:
- Reset then one word at index 0: in=64'h1122334455667788, is_last=1, byte_num=3 -> word0=64'h1122330600000000, words1..7=0, word8=64'h80, out_last=1, out_valid rises 9 cycles after acceptance.
- Nine full words 64'h0..01 through 64'h0..09 (is_last=0), then is_last with byte_num=0 -> block 1 = words 1..9 with out_last=0; block 2 word0=64'h0600000000000000, word8=64'h80, out_last=1.
- Eight full words, then a 9th word with is_last=1, byte_num=7, in=64'hAABBCCDDEEFF0011 -> word8=64'hAABBCCDDEEFF0086, out_last=1, in_ready low throughout FULL.
- Backpressure: hold out_ready=0 for 5 cycles in FULL -> out_valid stays 1, out unchanged, in_valid words not accepted; out_ready=1 gives one-cycle handshake, then in_ready=1 the next cycle.
- Assert reset_n=0 asynchronously while in PAD at cnt=4 -> out_valid=0, in_ready=1 after release; a new 1-word message produces a correctly padded block with no stale bytes.
- Garbage in low bytes: byte_num=1, in=64'hFFFFFFFFFFFFFFFF -> word=64'hFF06000000000000.
